// File: rtl/s2_reg_read.sv
// Register-read pipeline stage: 2R1W register file with writeback bypass,
// immediate sign extension and one registered boundary toward the ALU stage.
module s2_reg_read #(
  parameter int data_width   = 32,
  parameter int select_width = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [select_width-1:0] read_select_1,
  input  logic [select_width-1:0] read_select_2,
  input  logic [15:0]             immediate,
  input  logic                    data_source,
  input  logic [2:0]              alu_operation,
  input  logic [select_width-1:0] write_select,
  input  logic                    write_enable,
  input  logic [data_width-1:0]   wb_data,
  input  logic [select_width-1:0] wb_select,
  input  logic                    wb_enable,
  output logic [data_width-1:0]   operand_a,
  output logic [data_width-1:0]   operand_b,
  output logic [2:0]              alu_operation_out,
  output logic [select_width-1:0] write_select_out,
  output logic                    write_enable_out
);

  localparam int reg_count = 1 << select_width;

  logic [data_width-1:0]   mem_q [reg_count];
  logic [data_width-1:0]   read_a, read_b, imm_ext;
  logic [data_width-1:0]   operand_a_d, operand_b_d;
  logic [data_width-1:0]   operand_a_q, operand_b_q;
  logic [2:0]              alu_operation_q;
  logic [select_width-1:0] write_select_q;
  logic                    write_enable_q;

  // NOTE: the register file must clear on reset, so it is built from resettable
  // flops rather than a RAM macro; a writeback coincident with reset is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < reg_count; i++) mem_q[i] <= '0;
    end else if (wb_enable) begin
      mem_q[wb_select] <= wb_data;
    end
  end

  // The writeback stage's data is forwarded so a same-cycle read sees it.
  always_comb begin
    read_a = mem_q[read_select_1];
    read_b = mem_q[read_select_2];
    if (wb_enable && (wb_select == read_select_1)) read_a = wb_data;
    if (wb_enable && (wb_select == read_select_2)) read_b = wb_data;
  end

  assign imm_ext     = {{(data_width-16){immediate[15]}}, immediate};
  assign operand_a_d = read_a;
  assign operand_b_d = data_source ? imm_ext : read_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      alu_operation_q <= '0;
      write_select_q  <= '0;
      write_enable_q  <= 1'b0;
    end else begin
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      alu_operation_q <= alu_operation;
      write_select_q  <= write_select;
      write_enable_q  <= write_enable;
    end
  end

  assign operand_a         = operand_a_q;
  assign operand_b         = operand_b_q;
  assign alu_operation_out = alu_operation_q;
  assign write_select_out  = write_select_q;
  assign write_enable_out  = write_enable_q;

endmodule

// File: tb/tb_s2_reg_read.sv
// Directed self-checking bench for s2_reg_read: reset, write/read, bypass,
// immediate extension, control pass-through and register 0 behaviour.
module tb_s2_reg_read;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_select_1, read_select_2, write_select, wb_select;
  logic [15:0] immediate;
  logic        data_source, write_enable, wb_enable;
  logic [2:0]  alu_operation;
  logic [31:0] wb_data;
  logic [31:0] operand_a, operand_b;
  logic [2:0]  alu_operation_out;
  logic [4:0]  write_select_out;
  logic        write_enable_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  s2_reg_read dut (
    .clk               (clk),
    .reset             (reset),
    .read_select_1     (read_select_1),
    .read_select_2     (read_select_2),
    .immediate         (immediate),
    .data_source       (data_source),
    .alu_operation     (alu_operation),
    .write_select      (write_select),
    .write_enable      (write_enable),
    .wb_data           (wb_data),
    .wb_select         (wb_select),
    .wb_enable         (wb_enable),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .alu_operation_out (alu_operation_out),
    .write_select_out  (write_select_out),
    .write_enable_out  (write_enable_out)
  );

  // Advance one rising edge and settle 1 ns after it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    read_select_1 = '0;
    read_select_2 = '0;
    immediate     = '0;
    data_source   = 1'b0;
    alu_operation = '0;
    write_select  = '0;
    write_enable  = 1'b0;
    wb_data       = '0;
    wb_select     = '0;
    wb_enable     = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] sel, input logic [31:0] data);
    wb_enable = 1'b1;
    wb_select = sel;
    wb_data   = data;
    tick();
    wb_enable = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    #2;
    checks++;
    if ({operand_a, operand_b, alu_operation_out, write_select_out, write_enable_out} !== '0) begin
      failures++;
      $display("FAIL reset_initial: outputs a=%h b=%h op=%b ws=%0d we=%b, expected all 0",
               operand_a, operand_b, alu_operation_out, write_select_out, write_enable_out);
    end
    tick();
    reset = 1'b1;
    wb_write(5'd5, 32'h0BADF00D);
    wb_write(5'd9, 32'h99999999);
    // Load nonzero values on every output so the asynchronous clear is visible.
    read_select_1 = 5'd5; read_select_2 = 5'd9;
    alu_operation = 3'b111; write_select = 5'd21; write_enable = 1'b1;
    tick();
    checks++;
    if (operand_a !== 32'h0BADF00D || operand_b !== 32'h99999999 || write_enable_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload: a=%h b=%h we=%b, expected a=0badf00d b=99999999 we=1",
               operand_a, operand_b, write_enable_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({operand_a, operand_b, alu_operation_out, write_select_out, write_enable_out} !== '0) begin
      failures++;
      $display("FAIL reset_async_clear: a=%h b=%h op=%b ws=%0d we=%b, expected all 0",
               operand_a, operand_b, alu_operation_out, write_select_out, write_enable_out);
    end
    // A writeback held across an edge during reset must be discarded.
    set_idle();
    wb_enable = 1'b1; wb_select = 5'd5; wb_data = 32'hFFFFFFFF;
    tick();
    reset = 1'b1;
    set_idle();
    read_select_1 = 5'd5; read_select_2 = 5'd9;
    tick();
    checks++;
    if (operand_a !== 32'h0 || operand_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_regfile_clear: r5=%h r9=%h, expected 0 and 0", operand_a, operand_b);
    end
  endtask

  task automatic test_write_read();
    set_idle();
    wb_write(5'd3, 32'hDEADBEEF);
    read_select_1 = 5'd3; read_select_2 = 5'd3; data_source = 1'b0;
    tick();
    checks++;
    if (operand_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read_a: operand_a=%h, expected deadbeef", operand_a);
    end
    checks++;
    if (operand_b !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL same_select_b: operand_b=%h, expected deadbeef", operand_b);
    end
  endtask

  task automatic test_bypass();
    set_idle();
    wb_write(5'd7, 32'h11111111);
    wb_enable = 1'b1; wb_select = 5'd7; wb_data = 32'h12345678;
    read_select_1 = 5'd7; read_select_2 = 5'd7; data_source = 1'b0;
    tick();
    checks++;
    if (operand_a !== 32'h12345678 || operand_b !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_both: a=%h b=%h, expected 12345678 and 12345678", operand_a, operand_b);
    end
    // Bypass must target only the matching select.
    wb_select = 5'd8; wb_data = 32'h87654321;
    read_select_1 = 5'd7; read_select_2 = 5'd8;
    tick();
    checks++;
    if (operand_a !== 32'h12345678 || operand_b !== 32'h87654321) begin
      failures++;
      $display("FAIL bypass_split: a=%h b=%h, expected 12345678 and 87654321", operand_a, operand_b);
    end
    wb_enable = 1'b0; wb_data = 32'hFFFF0000;
    tick();
    checks++;
    if (operand_a !== 32'h12345678 || operand_b !== 32'h87654321) begin
      failures++;
      $display("FAIL bypass_stored: a=%h b=%h, expected 12345678 and 87654321", operand_a, operand_b);
    end
  endtask

  task automatic test_immediate();
    set_idle();
    wb_write(5'd2, 32'hAAAA0000);
    read_select_1 = 5'd2; read_select_2 = 5'd2; data_source = 1'b1;
    immediate = 16'h8000;
    tick();
    checks++;
    if (operand_b !== 32'hFFFF8000 || operand_a !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL imm_neg: a=%h b=%h, expected aaaa0000 and ffff8000", operand_a, operand_b);
    end
    immediate = 16'h7FFF;
    tick();
    checks++;
    if (operand_b !== 32'h00007FFF) begin
      failures++;
      $display("FAIL imm_pos: operand_b=%h, expected 00007fff", operand_b);
    end
    // Bypass of the same register must not leak into operand_b.
    immediate = 16'h0001; wb_enable = 1'b1; wb_select = 5'd2; wb_data = 32'h55555555;
    tick();
    checks++;
    if (operand_b !== 32'h00000001 || operand_a !== 32'h55555555) begin
      failures++;
      $display("FAIL imm_vs_bypass: a=%h b=%h, expected 55555555 and 00000001", operand_a, operand_b);
    end
  endtask

  task automatic test_pass_through();
    set_idle();
    alu_operation = 3'b101; write_select = 5'd31; write_enable = 1'b1;
    tick();
    checks++;
    if (alu_operation_out !== 3'b101 || write_select_out !== 5'd31 || write_enable_out !== 1'b1) begin
      failures++;
      $display("FAIL pass_through: op=%b ws=%0d we=%b, expected 101 31 1",
               alu_operation_out, write_select_out, write_enable_out);
    end
    alu_operation = 3'b010; write_select = 5'd12; write_enable = 1'b0;
    tick();
    checks++;
    if (alu_operation_out !== 3'b010 || write_select_out !== 5'd12 || write_enable_out !== 1'b0) begin
      failures++;
      $display("FAIL pass_through_2: op=%b ws=%0d we=%b, expected 010 12 0",
               alu_operation_out, write_select_out, write_enable_out);
    end
    alu_operation = 3'b101; write_select = 5'd31; write_enable = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (alu_operation_out !== 3'b000 || write_select_out !== 5'd0 || write_enable_out !== 1'b0) begin
      failures++;
      $display("FAIL pass_through_reset_hold: op=%b ws=%0d we=%b, expected 000 0 0",
               alu_operation_out, write_select_out, write_enable_out);
    end
    #3 reset = 1'b1;
    tick();
    checks++;
    if (alu_operation_out !== 3'b101 || write_select_out !== 5'd31 || write_enable_out !== 1'b1) begin
      failures++;
      $display("FAIL pass_through_resume: op=%b ws=%0d we=%b, expected 101 31 1",
               alu_operation_out, write_select_out, write_enable_out);
    end
  endtask

  task automatic test_back_to_back();
    set_idle();
    wb_write(5'd0, 32'hCAFEF00D);
    wb_write(5'd31, 32'h31313131);
    read_select_1 = 5'd0; read_select_2 = 5'd31;
    tick();
    checks++;
    if (operand_a !== 32'hCAFEF00D || operand_b !== 32'h31313131) begin
      failures++;
      $display("FAIL reg0_and_r31: a=%h b=%h, expected cafef00d and 31313131", operand_a, operand_b);
    end
    // wb_enable=0 with live select/data must leave the file untouched.
    wb_enable = 1'b0; wb_select = 5'd0; wb_data = 32'h0000DEAD;
    tick();
    tick();
    checks++;
    if (operand_a !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL write_disabled_hold: r0=%h, expected cafef00d", operand_a);
    end
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_immediate();
    test_pass_through();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
